// File: rtl/clk_gate_pkg.sv
// clk_gate_pkg: shared state encodings and widths for the clock-gate controller
package clk_gate_pkg;
   typedef enum logic [1:0] {
      ST_ACTIVE = 2'd0,
      ST_GATED  = 2'd1,
      ST_WAKING = 2'd2
   } state_t;
   localparam int IDLE_W = 8;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: synchronous-clear up counter that sticks at all-ones
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);
   logic [W-1:0] cnt_q;
   always_ff @(posedge clk) begin
      if (clr_i) cnt_q <= '0;
      else if (inc_i && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
   end
   assign cnt_o = cnt_q;
endmodule

// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl: idle-driven clock-gate enable with settle window and wake handshake
module clk_gate_ctrl
   import clk_gate_pkg::*;
#(
   parameter int IDLE_THRESH = 16,
   parameter int WAKE_DELAY  = 2,
   parameter int CNT_W       = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              allow_gate_i,
   input  logic              busy_i,
   input  logic              wake_req_i,
   output logic              clk_en_o,
   output logic              gated_o,
   output logic              wake_ack_o,
   output logic [IDLE_W-1:0] idle_cnt_o,
   output logic [CNT_W-1:0]  gate_count_o
);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_THRESH - 1);
   localparam logic [7:0] WAKE_LAST = 8'((WAKE_DELAY == 0) ? 0 : WAKE_DELAY - 1);
   state_t            state_q;
   logic              clk_en_q, gated_q, ack_q, ack_done_q;
   logic [IDLE_W-1:0] idle_q;
   logic [7:0]        timer_q;
   logic              idle, wake, gate_d;
   assign idle   = allow_gate_i & ~busy_i & ~wake_req_i;
   assign wake   = busy_i | wake_req_i | ~allow_gate_i;
   assign gate_d = rst_n && state_q == ST_ACTIVE && idle && idle_q == IDLE_LAST;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_ACTIVE;
         clk_en_q   <= 1'b1;
         gated_q    <= 1'b0;
         ack_q      <= 1'b0;
         ack_done_q <= 1'b0;
         idle_q     <= '0;
         timer_q    <= '0;
      end else begin
         case (state_q)
            ST_ACTIVE: begin
               if (gate_d) begin
                  state_q  <= ST_GATED;
                  clk_en_q <= 1'b0;
                  gated_q  <= 1'b1;
                  idle_q   <= '0;
               end else idle_q <= idle ? idle_q + 1'b1 : '0;
            end
            ST_GATED: begin
               if (wake) begin
                  state_q  <= (WAKE_DELAY == 0) ? ST_ACTIVE : ST_WAKING;
                  clk_en_q <= 1'b1;
                  gated_q  <= 1'b0;
                  timer_q  <= '0;
               end
            end
            default: begin
               // settle window: only reset can interrupt it
               idle_q  <= '0;
               timer_q <= timer_q + 1'b1;
               if (timer_q == WAKE_LAST) state_q <= ST_ACTIVE;
            end
         endcase
         ack_q <= state_q == ST_ACTIVE && wake_req_i && !ack_done_q;
         if (!wake_req_i) ack_done_q <= 1'b0;
         else if (state_q == ST_ACTIVE) ack_done_q <= 1'b1;
      end
   end
   sat_counter #(.W(CNT_W)) u_cnt (
      .clk   (clk),
      .clr_i (~rst_n),
      .inc_i (gate_d),
      .cnt_o (gate_count_o)
   );
   assign clk_en_o   = clk_en_q;
   assign gated_o    = gated_q;
   assign wake_ack_o = ack_q;
   assign idle_cnt_o = idle_q;
endmodule

// File: tb/tb_clk_gate_ctrl.sv
// tb_clk_gate_ctrl: table-driven and sequence checks of clk_gate_ctrl
module tb_clk_gate_ctrl;
   typedef struct packed {
      logic       rst_n, allow, busy, wreq, en, g, ack;
      logic [7:0] ic;
      logic [3:0] gc;
   } vec_t;
   logic       clk = 1'b0, rst_n = 1'b0, allow = 1'b0, busy = 1'b0, wreq = 1'b0;
   logic       en1, g1, ack1, en0, g0, ack0;
   logic [7:0] ic1, ic0;
   logic [3:0] gc1, gc0;
   int         tests = 0, fails = 0;
   vec_t       vecs[$];
   always #5 clk = ~clk;
   clk_gate_ctrl #(.IDLE_THRESH(4), .WAKE_DELAY(2), .CNT_W(4)) u1 (
      .clk(clk), .rst_n(rst_n), .allow_gate_i(allow), .busy_i(busy), .wake_req_i(wreq),
      .clk_en_o(en1), .gated_o(g1), .wake_ack_o(ack1), .idle_cnt_o(ic1), .gate_count_o(gc1));
   clk_gate_ctrl #(.IDLE_THRESH(4), .WAKE_DELAY(0), .CNT_W(4)) u0 (
      .clk(clk), .rst_n(rst_n), .allow_gate_i(allow), .busy_i(busy), .wake_req_i(wreq),
      .clk_en_o(en0), .gated_o(g0), .wake_ack_o(ack0), .idle_cnt_o(ic0), .gate_count_o(gc0));
   function automatic vec_t mk(input logic r, a, b, w, e, g, k, input logic [7:0] ic,
                               input logic [3:0] gc);
      return '{rst_n: r, allow: a, busy: b, wreq: w, en: e, g: g, ack: k, ic: ic, gc: gc};
   endfunction
   task automatic chk(input string name, input logic [14:0] act, input logic [14:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got en,g,ack,ic,gc=%b,%b,%b,%0d,%0d expected %b,%b,%b,%0d,%0d", name,
                  act[14], act[13], act[12], act[11:4], act[3:0],
                  exp[14], exp[13], exp[12], exp[11:4], exp[3:0]);
      end
   endtask
   task automatic step(input logic r, a, b, w);
      rst_n = r; allow = a; busy = b; wreq = w;
      @(posedge clk);
      #1;
   endtask
   initial begin
      vecs.push_back(mk(0,1,0,0, 1,0,0,0,0));
      vecs.push_back(mk(1,1,0,0, 1,0,0,1,0));
      vecs.push_back(mk(1,1,0,0, 1,0,0,2,0));
      vecs.push_back(mk(1,1,0,0, 1,0,0,3,0));
      vecs.push_back(mk(1,1,0,0, 0,1,0,0,1));
      vecs.push_back(mk(1,1,0,0, 0,1,0,0,1));
      vecs.push_back(mk(1,1,0,1, 1,0,0,0,1));
      vecs.push_back(mk(1,1,0,1, 1,0,0,0,1));
      vecs.push_back(mk(1,1,0,1, 1,0,0,0,1));
      vecs.push_back(mk(1,1,0,1, 1,0,1,0,1));
      vecs.push_back(mk(1,1,0,1, 1,0,0,0,1));
      vecs.push_back(mk(1,1,0,0, 1,0,0,1,1));
      vecs.push_back(mk(1,1,0,1, 1,0,1,0,1));
      vecs.push_back(mk(1,1,0,0, 1,0,0,1,1));
      vecs.push_back(mk(1,1,0,0, 1,0,0,2,1));
      vecs.push_back(mk(1,1,1,0, 1,0,0,0,1));
      vecs.push_back(mk(1,1,0,0, 1,0,0,1,1));
      vecs.push_back(mk(1,1,0,0, 1,0,0,2,1));
      vecs.push_back(mk(1,1,0,0, 1,0,0,3,1));
      vecs.push_back(mk(1,1,0,0, 0,1,0,0,2));
      vecs.push_back(mk(1,1,1,1, 1,0,0,0,2));
      vecs.push_back(mk(1,1,0,1, 1,0,0,0,2));
      vecs.push_back(mk(1,1,0,1, 1,0,0,0,2));
      vecs.push_back(mk(1,1,0,1, 1,0,1,0,2));
      vecs.push_back(mk(1,1,0,1, 1,0,0,0,2));
      vecs.push_back(mk(1,1,0,0, 1,0,0,1,2));
      for (int i = 0; i < 6; i++) vecs.push_back(mk(1,0,0,0, 1,0,0,0,2));
      vecs.push_back(mk(1,1,0,0, 1,0,0,1,2));
      vecs.push_back(mk(1,1,0,0, 1,0,0,2,2));
      vecs.push_back(mk(1,1,0,0, 1,0,0,3,2));
      vecs.push_back(mk(1,1,0,0, 0,1,0,0,3));
      vecs.push_back(mk(1,0,0,0, 1,0,0,0,3));
      vecs.push_back(mk(1,0,0,0, 1,0,0,0,3));
      vecs.push_back(mk(1,0,0,0, 1,0,0,0,3));
      vecs.push_back(mk(1,0,0,0, 1,0,0,0,3));
      vecs.push_back(mk(1,1,0,0, 1,0,0,1,3));
      vecs.push_back(mk(1,1,0,0, 1,0,0,2,3));
      vecs.push_back(mk(1,1,0,0, 1,0,0,3,3));
      vecs.push_back(mk(1,1,0,0, 0,1,0,0,4));
      vecs.push_back(mk(0,1,0,0, 1,0,0,0,0));
      vecs.push_back(mk(1,1,0,0, 1,0,0,1,0));
      foreach (vecs[i]) begin
         step(vecs[i].rst_n, vecs[i].allow, vecs[i].busy, vecs[i].wreq);
         chk($sformatf("vec%0d", i), {en1, g1, ack1, ic1, gc1},
             {vecs[i].en, vecs[i].g, vecs[i].ack, vecs[i].ic, vecs[i].gc});
      end
      step(0, 1, 0, 0);
      repeat (4) step(1, 1, 0, 0);
      chk("wd0_gated", {en0, g0, ack0, ic0, gc0}, {3'b010, 8'd0, 4'd1});
      step(1, 1, 0, 1);
      chk("wd0_detect", {en0, g0, ack0, ic0, gc0}, {3'b100, 8'd0, 4'd1});
      chk("wd2_detect", {en1, g1, ack1, ic1, gc1}, {3'b100, 8'd0, 4'd1});
      step(1, 1, 0, 1);
      chk("wd0_ack", {en0, g0, ack0, ic0, gc0}, {3'b101, 8'd0, 4'd1});
      chk("wd2_wait1", {en1, g1, ack1, ic1, gc1}, {3'b100, 8'd0, 4'd1});
      step(1, 1, 0, 1);
      chk("wd0_noack2", {en0, g0, ack0, ic0, gc0}, {3'b100, 8'd0, 4'd1});
      chk("wd2_wait2", {en1, g1, ack1, ic1, gc1}, {3'b100, 8'd0, 4'd1});
      step(1, 1, 0, 1);
      chk("wd2_ack", {en1, g1, ack1, ic1, gc1}, {3'b101, 8'd0, 4'd1});
      step(0, 1, 0, 0);
      for (int e = 1; e <= 19; e++) begin
         repeat (4) step(1, 1, 0, 0);
         chk($sformatf("sat_ev%0d", e), {en1, g1, ack1, ic1, gc1},
             {3'b010, 8'd0, 4'((e > 15) ? 15 : e)});
         repeat (3) step(1, 1, 1, 0);
      end
      chk("sat_final", {en1, g1, ack1, ic1, gc1}, {3'b100, 8'd0, 4'd15});
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
